// File: rtl/input_conditioner_channel.sv
// One input bit: N-stage synchroniser, debounce filter, rise/fall strobes and
// a minimum-hold detector on the accepted level.
module input_conditioner_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 5000000,
    parameter bit INVERT          = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise_stb,
    output logic o_fall_stb,
    output logic o_hold,
    output logic o_hold_stb
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   x;
    logic                   accept;

    // Sync flops reset to the inactive pin level so the corrected level starts at 0.
    assign x      = sync_q[SYNC_STAGES-1] ^ INVERT;
    assign accept = (x != o_level) && (db_cnt == DB_LAST);
    assign o_hold = (hold_cnt == HOLD_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q     <= {SYNC_STAGES{INVERT}};
            db_cnt     <= '0;
            o_level    <= 1'b0;
            o_rise_stb <= 1'b0;
            o_fall_stb <= 1'b0;
            hold_cnt   <= '0;
            o_hold_stb <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};

            if (x == o_level || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            if (accept) begin
                o_level <= x;
            end
            o_rise_stb <= accept & x;
            o_fall_stb <= accept & ~x;

            // Clearing on the falling accept drops o_hold together with o_level.
            if (!o_level || accept) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            o_hold_stb <= o_level && !accept && (hold_cnt == HOLD_PRE);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: per-channel conditioning plus a stretched,
// maskable CPU reset request driven by channel rise/hold strobes.
module input_conditioner #(
    parameter int                CHANNELS         = 8,
    parameter int                SYNC_STAGES      = 2,
    parameter int                DEBOUNCE_CYCLES  = 250000,
    parameter int                HOLD_CYCLES      = 5000000,
    parameter logic [CHANNELS-1:0] INVERT_MASK    = '0,
    parameter logic [CHANNELS-1:0] RST_EDGE_MASK  = '0,
    parameter logic [CHANNELS-1:0] RST_HOLD_MASK  = '0,
    parameter int                RST_PULSE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise_stb,
    output logic [CHANNELS-1:0] o_fall_stb,
    output logic [CHANNELS-1:0] o_hold,
    output logic [CHANNELS-1:0] o_hold_stb,
    output logic                o_rst_req
);

    localparam int RST_W = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LEN = RST_W'(RST_PULSE_CYCLES);

    logic [RST_W-1:0] rst_cnt;
    logic             trig;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        input_conditioner_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .INVERT          (INVERT_MASK[i])
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_pin      (i_in[i]),
            .o_level    (o_level[i]),
            .o_rise_stb (o_rise_stb[i]),
            .o_fall_stb (o_fall_stb[i]),
            .o_hold     (o_hold[i]),
            .o_hold_stb (o_hold_stb[i])
        );
    end

    // Any number of simultaneous channel triggers collapses into one reload.
    assign trig      = |((o_rise_stb & RST_EDGE_MASK) | (o_hold_stb & RST_HOLD_MASK));
    assign o_rst_req = (rst_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rst_cnt <= '0;
        end else if (trig) begin
            rst_cnt <= RST_LEN;
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - RST_W'(1);
        end
    end

endmodule
